serial_tx_param: RTL

//  Parametrised serial transmitter: accepts parallel words on a valid/ready handshake, buffers up to DEPTH words,
//  and serialises each as a framed bitstream on S_Data. Frame: start bit, data (LSB first), optional parity, stop bit(s).

---
 rtl/serial_tx_param_pkg.sv | 25 ++
 rtl/serial_tx_param_if.sv | 21 ++
 rtl/serial_tx_param_fifo.sv | 65 ++++++
 rtl/serial_tx_param.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/serial_tx_param_pkg.sv
// Shared definitions for the parametrised serial transmitter: FSM states,
// frame line levels and the parity helper.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        ST_ARM    = 3'd0,
        ST_IDLE   = 3'd1,
        ST_START  = 3'd2,
        ST_DATA   = 3'd3,
        ST_PARITY = 3'd4,
        ST_STOP   = 3'd5
    } tx_state_e;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    // Words are zero-extended into this width; the padding does not change the XOR.
    localparam int unsigned PARITY_MAX_W = 256;

    function automatic logic frame_parity(input logic [PARITY_MAX_W-1:0] word, input logic odd);
        return (^word) ^ odd;
    endfunction

endpackage

// File: rtl/serial_tx_param_if.sv
// Producer-side handshake plus the serial line outputs of the transmitter.
interface serial_tx_param_if #(
    parameter int unsigned DATA_W = 55
) ();
    logic [DATA_W-1:0] TX_Data;
    logic              TX_Data_Valid;
    logic              TX_Ready;
    logic              S_Data;
    logic              TX_Busy;
    logic              TX_Done;

    modport master (
        output TX_Data, TX_Data_Valid,
        input  TX_Ready, S_Data, TX_Busy, TX_Done
    );

    modport slave (
        input  TX_Data, TX_Data_Valid,
        output TX_Ready, S_Data, TX_Busy, TX_Done
    );
endinterface

// File: rtl/serial_tx_param_fifo.sv
// Word buffer in front of the serialiser; power-of-two depth so pointers wrap
// naturally. Synchronous active-low reset empties it.
module serial_tx_fifo #(
    parameter int unsigned DATA_W = 55,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              empty_o,
    output logic [CNT_W-1:0]  count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok_s;
    logic              pop_ok_s;

    // next-state pointers and occupancy
    always_comb begin
        push_ok_s = push_i && (count_q < CNT_W'(DEPTH));
        pop_ok_s  = pop_i && (count_q != CNT_W'(0));
        wr_d      = push_ok_s ? (wr_q + PTR_W'(1)) : wr_q;
        rd_d      = pop_ok_s ? (rd_q + PTR_W'(1)) : rd_q;
        if (push_ok_s && !pop_ok_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok_s && !push_ok_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // pointer and count registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // storage array; contents are only meaningful while counted as occupied
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign empty_o = (count_q == CNT_W'(0));
    assign count_o = count_q;

endmodule

// File: rtl/serial_tx_param.sv
// Parametrised framed serial transmitter: buffered valid/ready input, frame of
// start bit, LSB-first data, optional parity and stop bit(s) on S_Data.
module serial_tx_param
    import serial_tx_pkg::*;
#(
    parameter int unsigned DATA_W       = 55,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned CLKS_PER_BIT = 1,
    parameter int unsigned PARITY_EN    = 0,
    parameter int unsigned PARITY_ODD   = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic             Clk_S,
    input  logic             Rst_n,
    serial_tx_param_if.slave tx_if
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);
    localparam int unsigned CYC_W = $clog2(CLKS_PER_BIT + 1);

    tx_state_e         state_q;
    logic [DATA_W-1:0] shift_q;
    logic              parity_q;
    logic [BIT_W-1:0]  bit_q;
    logic [CYC_W-1:0]  cyc_q;
    logic              s_data_q;
    logic              busy_q;
    logic              done_q;

    logic [DATA_W-1:0] fifo_head_s;
    logic              fifo_empty_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic              ready_s;
    logic              push_s;
    logic              pop_s;
    logic              last_cyc_s;
    logic              last_data_s;
    logic              last_stop_s;
    logic              head_parity_s;

    serial_tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (Clk_S),
        .rst_ni  (Rst_n),
        .push_i  (push_s),
        .data_i  (tx_if.TX_Data),
        .pop_i   (pop_s),
        .head_o  (fifo_head_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // handshake, bit-timing terminal counts and FIFO pop decision
    always_comb begin
        last_cyc_s    = (cyc_q == CYC_W'(CLKS_PER_BIT - 1));
        last_data_s   = (bit_q == BIT_W'(DATA_W - 1));
        last_stop_s   = (bit_q == BIT_W'(STOP_BITS - 1));
        ready_s       = (state_q != ST_ARM) && (fifo_count_s < CNT_W'(DEPTH));
        push_s        = tx_if.TX_Data_Valid && ready_s;
        head_parity_s = frame_parity(PARITY_MAX_W'(fifo_head_s), (PARITY_ODD != 0));
        case (state_q)
            ST_IDLE: pop_s = !fifo_empty_s;
            ST_STOP: pop_s = last_cyc_s && last_stop_s && !fifo_empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Frame FSM. Line outputs are computed from the current state, so they
    // trail the state by one edge and a popped word hits the line two edges
    // after it was pushed.
    always_ff @(posedge Clk_S) begin
        if (!Rst_n) begin
            state_q  <= ST_ARM;
            shift_q  <= '0;
            parity_q <= 1'b0;
            bit_q    <= '0;
            cyc_q    <= '0;
            s_data_q <= LINE_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            s_data_q <= LINE_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                ST_ARM: begin
                    if (!tx_if.TX_Data_Valid) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (pop_s) begin
                        shift_q  <= fifo_head_s;
                        parity_q <= head_parity_s;
                        cyc_q    <= '0;
                        state_q  <= ST_START;
                    end
                end
                ST_START: begin
                    s_data_q <= START_LEVEL;
                    busy_q   <= 1'b1;
                    if (last_cyc_s) begin
                        cyc_q   <= '0;
                        bit_q   <= '0;
                        state_q <= ST_DATA;
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                ST_DATA: begin
                    s_data_q <= shift_q[0];
                    busy_q   <= 1'b1;
                    if (last_cyc_s) begin
                        cyc_q   <= '0;
                        shift_q <= shift_q >> 1;
                        if (last_data_s) begin
                            bit_q   <= '0;
                            state_q <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                ST_PARITY: begin
                    s_data_q <= parity_q;
                    busy_q   <= 1'b1;
                    if (last_cyc_s) begin
                        cyc_q   <= '0;
                        bit_q   <= '0;
                        state_q <= ST_STOP;
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                ST_STOP: begin
                    s_data_q <= STOP_LEVEL;
                    busy_q   <= 1'b1;
                    done_q   <= last_cyc_s && last_stop_s;
                    if (last_cyc_s) begin
                        cyc_q <= '0;
                        if (last_stop_s) begin
                            bit_q <= '0;
                            // back-to-back frames: straight to START with no idle bit
                            if (pop_s) begin
                                shift_q  <= fifo_head_s;
                                parity_q <= head_parity_s;
                                state_q  <= ST_START;
                            end else begin
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            bit_q <= bit_q + BIT_W'(1);
                        end
                    end else begin
                        cyc_q <= cyc_q + CYC_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_ARM;
                end
            endcase
        end
    end

    assign tx_if.TX_Ready = ready_s;
    assign tx_if.S_Data   = s_data_q;
    assign tx_if.TX_Busy  = busy_q;
    assign tx_if.TX_Done  = done_q;

endmodule
